// File: rtl/memory_req_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_req_ctrl_pkg                                                        |
// | Shared types and constants for the memory request controller.             |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package memory_req_ctrl_pkg;

    localparam int c_rsp_depth_min = 2;

    // Default memory word and the response entry built from it; the top
    // rebuilds the same layout from its own data_t.
    typedef logic [1:0] word_t;

    typedef struct packed {
        logic  is_wr;
        word_t data;
    } rsp_entry_t;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_if                                                                  |
// | Single-cycle memory port: read data returns one cycle after enable.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface memory_if #(
    parameter int  DEPTH  = 2,
    parameter type data_t = logic [1:0]
) ();
    import memory_req_ctrl_pkg::*;

    localparam int ADDR_W = addr_width(DEPTH);

    logic              enable;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    data_t             write_data;
    data_t             read_data;

    modport src (output enable, wr_en, addr, write_data, input read_data);
    modport dst (input enable, wr_en, addr, write_data, output read_data);

endinterface
`default_nettype wire

// File: rtl/memory_req_ctrl_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_req_ctrl_fifo                                                       |
// | In-order response FIFO with occupancy count; any DEPTH >= 2.              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module memory_req_ctrl_fifo #(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int c_ptr_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_last_i = DEPTH - 1;
    localparam int c_one_i  = 1;

    localparam logic [c_ptr_w-1:0] c_ptr_last = c_last_i[c_ptr_w-1:0];
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_one_i[c_ptr_w-1:0];
    localparam logic [CNT_W-1:0]   c_cnt_one  = c_one_i[CNT_W-1:0];
    localparam logic [CNT_W-1:0]   c_cnt_full = DEPTH[CNT_W-1:0];

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = push & (r_count != c_cnt_full);
    assign w_do_pop  = pop & (r_count != '0);

    assign head  = r_mem[r_rptr];
    assign empty = (r_count == '0);
    assign count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            // Explicit wrap so non-power-of-two depths stay in range
            if (w_do_push) begin
                r_wptr <= (r_wptr == c_ptr_last) ? '0 : r_wptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rptr <= (r_rptr == c_ptr_last) ? '0 : r_rptr + c_ptr_one;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_req_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_req_ctrl                                                            |
// | Credit-based initiator for memory_if with an in-order response channel.   |
// | Optional write acks: define MEMORY_REQ_CTRL_WRACK_EN.                      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module memory_req_ctrl
    import memory_req_ctrl_pkg::*;
#(
    parameter  int  DEPTH     = 2,
    parameter  type data_t    = logic [1:0],
    parameter  int  RSP_DEPTH = 4,
    localparam int  ADDR_W    = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  data_t             cmd_wdata,
    memory_if.src             mem_port,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output data_t             rsp_data,
    output logic              rsp_is_wr
);

    localparam int c_data_w = $bits(data_t);
`ifdef MEMORY_REQ_CTRL_WRACK_EN
    localparam int c_entry_w = c_data_w + 1;
`else
    localparam int c_entry_w = c_data_w;
`endif
    localparam int c_cnt_w = $clog2(RSP_DEPTH + 1);

    localparam logic [c_cnt_w:0] c_credit_lim = RSP_DEPTH[c_cnt_w:0];

    generate
        if (RSP_DEPTH < c_rsp_depth_min) begin : g_bad_rsp_depth
            $error("memory_req_ctrl: RSP_DEPTH must be at least %0d", c_rsp_depth_min);
        end
    endgenerate

    logic                 r_inflight;
    logic                 w_need_rsp;
    logic                 w_credit_ok;
    logic                 w_fire;
    logic                 w_pop;
    logic                 w_empty;
    logic [c_cnt_w-1:0]   w_count;
    logic [c_cnt_w:0]     w_used;
    logic [c_entry_w-1:0] w_push_data;
    logic [c_entry_w-1:0] w_head;

    // Credit ignores a same-cycle pop so rsp_ready never reaches cmd_ready
    assign w_used      = {1'b0, w_count} + {{c_cnt_w{1'b0}}, r_inflight};
    assign w_credit_ok = (w_used < c_credit_lim);
    assign cmd_ready   = ~rst & (~w_need_rsp | w_credit_ok);
    assign w_fire      = cmd_valid & cmd_ready;

    assign mem_port.enable     = w_fire;
    assign mem_port.wr_en      = cmd_wr;
    assign mem_port.addr       = cmd_addr;
    assign mem_port.write_data = cmd_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_fire & w_need_rsp;
        end
    end

    assign rsp_valid = ~w_empty;
    assign w_pop     = rsp_valid & rsp_ready;

`ifdef MEMORY_REQ_CTRL_WRACK_EN
    typedef struct packed {
        logic  is_wr;
        data_t data;
    } entry_t;

    logic   r_inflight_wr;
    entry_t w_push_entry;
    entry_t w_head_entry;

    assign w_need_rsp = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight_wr <= 1'b0;
        end else begin
            r_inflight_wr <= w_fire & cmd_wr;
        end
    end

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.is_wr = r_inflight_wr;
        w_push_entry.data  = r_inflight_wr ? '0 : mem_port.read_data;
    end

    assign w_push_data  = w_push_entry;
    assign w_head_entry = w_head;
    assign rsp_is_wr    = rsp_valid & w_head_entry.is_wr;
    assign rsp_data     = rsp_valid ? w_head_entry.data : '0;
`else
    assign w_need_rsp  = ~cmd_wr;
    assign w_push_data = mem_port.read_data;
    assign rsp_is_wr   = 1'b0;
    assign rsp_data    = rsp_valid ? w_head : '0;
`endif

    memory_req_ctrl_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_inflight),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .count     (w_count)
    );

endmodule
`default_nettype wire
